// File: rtl/sipp_datapath.sv
// SIPP datapath: program counter, instruction register, 16x16 register file
// with two combinational read ports and one write port, a small ALU, and the
// combinational data-memory interface. All sequencing decisions come from the
// external controller through the single-bit and 2-bit control strobes.
module sipp_datapath (
   input  logic        clk,
   input  logic        rst,

   input  logic        ir_ld,
   input  logic        pc_ld,
   input  logic        pc_clr,
   input  logic        pc_inc,
   input  logic        rf_w_wr,
   input  logic        rf_p_rd,
   input  logic        rf_q_rd,
   input  logic        rf_p_addr_sel,
   input  logic        d_rd,
   input  logic        d_wr,
   input  logic [1:0]  rf_w_data_sel,
   input  logic [1:0]  alu_s,

   output logic [15:0] ir,
   output logic        rf_p_zero,

   output logic [7:0]  i_addr,
   input  logic [15:0] i_data,

   output logic [7:0]  d_addr,
   output logic [15:0] d_wdata,
   output logic        d_we,
   output logic        d_re,
   input  logic [15:0] d_rdata
);

   localparam logic       P_SEL_A     = 1'b0;
   localparam logic       P_SEL_B     = 1'b1;

   localparam logic [1:0] W_SEL_ALU   = 2'd0;
   localparam logic [1:0] W_SEL_MEM   = 2'd1;
   localparam logic [1:0] W_SEL_IR    = 2'd2;
   localparam logic [1:0] W_SEL_RSVD  = 2'd3;

   localparam logic [1:0] ALU_ADD     = 2'd0;
   localparam logic [1:0] ALU_SUBTR   = 2'd1;
   localparam logic [1:0] ALU_PASS_P  = 2'd2;
   localparam logic [1:0] ALU_ZERO    = 2'd3;

   logic [7:0]  pc_q, pc_d;
   logic [15:0] ir_q, ir_d;
   logic [15:0] rf_q [16];
   logic [15:0] rf_d [16];

   logic [3:0]  ra, rb, rc;
   logic [7:0]  ir_off;
   logic [15:0] ir_sext;

   logic [3:0]  p_addr, q_addr, w_addr;
   logic [15:0] rf_p_data, rf_q_data;
   logic [15:0] alu_y;
   logic [15:0] rf_w_data;

   assign ra      = ir_q[11:8];
   assign rb      = ir_q[7:4];
   assign rc      = ir_q[3:0];
   assign ir_off  = ir_q[7:0];
   assign ir_sext = {{8{ir_q[7]}}, ir_q[7:0]};

   // PC next-state: clear beats relative jump beats increment.
   // Adding the raw 8-bit offset is the same as adding its sign extension
   // modulo 256, so no explicit widening is needed.
   always_comb begin
      pc_d = pc_q;
      if (pc_clr) begin
         pc_d = 8'h00;
      end else if (pc_ld) begin
         pc_d = pc_q + ir_off;
      end else if (pc_inc) begin
         pc_d = pc_q + 8'd1;
      end
   end

   // IR next-state: capture the word addressed by the current (pre-update) PC.
   always_comb begin
      ir_d = ir_q;
      if (ir_ld) begin
         ir_d = i_data;
      end
   end

   // Register file address decode.
   always_comb begin
      p_addr = (rf_p_addr_sel == P_SEL_B) ? rb : ra;
      q_addr = rc;
      w_addr = ra;
   end

   // Read ports: disabled ports present zero so the ALU sees a clean operand.
   always_comb begin
      rf_p_data = 16'h0000;
      rf_q_data = 16'h0000;
      if (rf_p_rd) begin
         rf_p_data = rf_q[p_addr];
      end
      if (rf_q_rd) begin
         rf_q_data = rf_q[q_addr];
      end
   end

   // ALU: wraps modulo 2^16, no flags.
   always_comb begin
      alu_y = 16'h0000;
      case (alu_s)
         ALU_ADD:    alu_y = rf_p_data + rf_q_data;
         ALU_SUBTR:  alu_y = rf_p_data - rf_q_data;
         ALU_PASS_P: alu_y = rf_p_data;
         ALU_ZERO:   alu_y = 16'h0000;
         default:    alu_y = 16'h0000;
      endcase
   end

   // Write-data mux. Memory data is taken exactly as presented on d_rdata,
   // even when a store to the same address happens in this cycle.
   always_comb begin
      rf_w_data = 16'h0000;
      case (rf_w_data_sel)
         W_SEL_ALU:  rf_w_data = alu_y;
         W_SEL_MEM:  rf_w_data = d_rdata;
         W_SEL_IR:   rf_w_data = ir_sext;
         W_SEL_RSVD: rf_w_data = 16'h0000;
         default:    rf_w_data = 16'h0000;
      endcase
   end

   // Register file next-state: only the Ra entry can change, and only on a write.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         rf_d[i] = rf_q[i];
      end
      if (rf_w_wr) begin
         rf_d[w_addr] = rf_w_data;
      end
   end

   // State registers; synchronous reset overrides every control strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q <= 8'h00;
         ir_q <= 16'h0000;
         for (int i = 0; i < 16; i++) begin
            rf_q[i] <= 16'h0000;
         end
      end else begin
         pc_q <= pc_d;
         ir_q <= ir_d;
         for (int i = 0; i < 16; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   // Status and memory-facing outputs, all combinational from current state.
   always_comb begin
      ir        = ir_q;
      rf_p_zero = (rf_p_data == 16'h0000);
      i_addr    = pc_q;
      d_addr    = ir_q[7:0];
      d_wdata   = rf_p_data;
      d_we      = d_wr;
      d_re      = d_rd;
   end

endmodule
